// File: rtl/wb_timer_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the user-area timer slave.
// A stall watchdog aborts any granted cycle that the slave never acknowledges.
module wb_timer_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_wbs_cyc_i,
  input  logic        m0_wbs_stb_i,
  input  logic        m0_wbs_we_i,
  input  logic [31:0] m0_wbs_adr_i,
  input  logic [31:0] m0_wbs_dat_i,
  input  logic [3:0]  m0_wbs_sel_i,
  output logic        m0_wbs_ack_o,
  output logic        m0_wbs_err_o,
  output logic [31:0] m0_wbs_dat_o,

  input  logic        m1_wbs_cyc_i,
  input  logic        m1_wbs_stb_i,
  input  logic        m1_wbs_we_i,
  input  logic [31:0] m1_wbs_adr_i,
  input  logic [31:0] m1_wbs_dat_i,
  input  logic [3:0]  m1_wbs_sel_i,
  output logic        m1_wbs_ack_o,
  output logic        m1_wbs_err_o,
  output logic [31:0] m1_wbs_dat_o,

  output logic        s_wbs_cyc_o,
  output logic        s_wbs_stb_o,
  output logic        s_wbs_we_o,
  output logic [31:0] s_wbs_adr_o,
  output logic [31:0] s_wbs_dat_o,
  output logic [3:0]  s_wbs_sel_o,
  input  logic        s_wbs_ack_i,
  input  logic [31:0] s_wbs_dat_i,

  output logic [1:0]  grant_o
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255 || (2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_badParams
    $error("wb_timer_arbiter: TIMEOUT_CYCLES must be 2..255 and fit in CNT_W bits");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_nextState;
  state_t           w_pick;
  logic             r_lastGrant;
  logic [CNT_W-1:0] r_wdog;
  logic             w_grantStb;
  logic             w_timeout;

  // r_lastGrant=1 means m1 was served last, so m0 wins the next tie.
  always_comb begin
    w_pick = IDLE;
    if (m0_wbs_cyc_i && m1_wbs_cyc_i) begin
      w_pick = r_lastGrant ? GNT0 : GNT1;
    end else if (m0_wbs_cyc_i) begin
      w_pick = GNT0;
    end else if (m1_wbs_cyc_i) begin
      w_pick = GNT1;
    end
  end

  always_comb begin
    w_grantStb = 1'b0;
    case (r_state)
      GNT0:    w_grantStb = m0_wbs_cyc_i & m0_wbs_stb_i;
      GNT1:    w_grantStb = m1_wbs_cyc_i & m1_wbs_stb_i;
      default: w_grantStb = 1'b0;
    endcase
  end

  // An ack in the same cycle the limit is reached still completes the beat.
  assign w_timeout = w_grantStb & ~s_wbs_ack_i & (r_wdog == LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_lastGrant <= 1'b1;
      r_wdog      <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState == GNT0) begin
        r_lastGrant <= 1'b0;
      end else if (w_nextState == GNT1) begin
        r_lastGrant <= 1'b1;
      end
      if (w_grantStb && !s_wbs_ack_i && !w_timeout) begin
        r_wdog <= r_wdog + CNT_W'(1);
      end else begin
        r_wdog <= '0;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, ABORT: w_nextState = w_pick;
      GNT0: begin
        if (!m0_wbs_cyc_i) begin
          w_nextState = m1_wbs_cyc_i ? GNT1 : IDLE;
        end else if (w_timeout) begin
          w_nextState = ABORT;
        end
      end
      GNT1: begin
        if (!m1_wbs_cyc_i) begin
          w_nextState = m0_wbs_cyc_i ? GNT0 : IDLE;
        end else if (w_timeout) begin
          w_nextState = ABORT;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Slave responses reach only the grantee; IDLE and ABORT swallow any stray ack.
  always_comb begin
    s_wbs_cyc_o  = 1'b0;
    s_wbs_stb_o  = 1'b0;
    s_wbs_we_o   = 1'b0;
    s_wbs_adr_o  = '0;
    s_wbs_dat_o  = '0;
    s_wbs_sel_o  = '0;
    m0_wbs_ack_o = 1'b0;
    m0_wbs_err_o = 1'b0;
    m0_wbs_dat_o = '0;
    m1_wbs_ack_o = 1'b0;
    m1_wbs_err_o = 1'b0;
    m1_wbs_dat_o = '0;
    grant_o      = 2'b00;
    case (r_state)
      GNT0: begin
        s_wbs_cyc_o  = m0_wbs_cyc_i;
        s_wbs_stb_o  = m0_wbs_cyc_i & m0_wbs_stb_i;
        s_wbs_we_o   = m0_wbs_we_i;
        s_wbs_adr_o  = m0_wbs_adr_i;
        s_wbs_dat_o  = m0_wbs_dat_i;
        s_wbs_sel_o  = m0_wbs_sel_i;
        m0_wbs_ack_o = s_wbs_ack_i;
        m0_wbs_dat_o = s_wbs_dat_i;
        grant_o      = 2'b01;
      end
      GNT1: begin
        s_wbs_cyc_o  = m1_wbs_cyc_i;
        s_wbs_stb_o  = m1_wbs_cyc_i & m1_wbs_stb_i;
        s_wbs_we_o   = m1_wbs_we_i;
        s_wbs_adr_o  = m1_wbs_adr_i;
        s_wbs_dat_o  = m1_wbs_dat_i;
        s_wbs_sel_o  = m1_wbs_sel_i;
        m1_wbs_ack_o = s_wbs_ack_i;
        m1_wbs_dat_o = s_wbs_dat_i;
        grant_o      = 2'b10;
      end
      ABORT: begin
        m0_wbs_err_o = ~r_lastGrant;
        m1_wbs_err_o = r_lastGrant;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/wb_timer_arbiter.md
Name: wb_timer_arbiter

Overview:
Two-master Wishbone round-robin arbiter that shares one Wishbone slave port (the user-area timer) between the rvj1 core data port (m0) and the Caravel management wishbone (m1). It grants one master per bus cycle, routes the grantee's signals to the slave and routes the slave's responses back to the grantee only. A stall watchdog terminates any cycle that the slave never acknowledges.

Parameters:
TIMEOUT_CYCLES, 16, cycles with stb high and no ack before the arbiter aborts the cycle; legal range 2..255.
CNT_W, 8, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk_i  in  1  single clock
rst_i  in  1  synchronous, active-high reset
m0_wbs_cyc_i / m0_wbs_stb_i / m0_wbs_we_i  in  1 each  master 0 bus-cycle, strobe and write-enable
m0_wbs_adr_i / m0_wbs_dat_i  in  32 each  master 0 address and write data
m0_wbs_sel_i  in  4  master 0 byte selects
m0_wbs_ack_o / m0_wbs_err_o  out  1 each  master 0 acknowledge and error
m0_wbs_dat_o  out  32  master 0 read data
m1_*  same set as m0_*  master 1
s_wbs_cyc_o / s_wbs_stb_o / s_wbs_we_o  out  1 each  slave bus-cycle, strobe and write-enable
s_wbs_adr_o / s_wbs_dat_o  out  32 each  slave address and write data
s_wbs_sel_o  out  4  slave byte selects
s_wbs_ack_i  in  1  slave acknowledge
s_wbs_dat_i  in  32  slave read data
grant_o  out  2  one-hot current grant (debug and status)

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i. In the reset cycle: state=IDLE, last_grant=1 (so m0 wins the first tie), watchdog=0, err pulses=0.
- Output values after reset: all slave outputs 0, all master ack/err/dat outputs 0, grant_o=2'b00.
- FSM states: IDLE, GNT0, GNT1, ABORT. State, last_grant and the watchdog counter are registered. All bus outputs are combinational decodes of the state and the inputs.
- IDLE:
  - m0_cyc only -> GNT0. m1_cyc only -> GNT1.
  - Both -> grant the master that is not last_grant.
  - Neither -> stay in IDLE.
  - Grant latency: 1 cycle from cyc rising to the slave seeing the request.
- GNTn (n = 0 or 1):
  - s_cyc_o = mn_cyc_i; s_stb_o = mn_cyc_i & mn_stb_i.
  - we, adr, dat and sel are muxed from master n.
  - mn_ack_o = s_ack_i; mn_dat_o = s_dat_i.
  - The other master sees ack=0, err=0, dat=0.
  - grant_o[n]=1. last_grant<=n on entry.
- Release: when mn_cyc_i=0 in GNTn:
  - if the other master's cyc=1, go directly to GNT(other) (no idle gap);
  - else go to IDLE.
  - The grant is held for the whole cyc, including multiple stb/ack beats.
- Watchdog:
  - In GNTn, the counter increments each cycle with stb=1 and s_ack_i=0.
  - It clears on s_ack_i=1, on stb=0, and on leaving GNTn.
  - When counter == TIMEOUT_CYCLES-1 and there is still no ack -> go to ABORT.
- ABORT (1 cycle):
  - All slave outputs are 0.
  - mn_err_o=1 for exactly this cycle; mn_ack_o=0.
  - Next state is chosen as from IDLE, with last_grant=n, so the other master wins a tie.
- Ack/timeout collision: s_ack_i=1 in the same cycle the count hits the limit -> the ack wins; no ABORT.
- Data integrity: s_ack_i arriving while in IDLE or ABORT is ignored and never forwarded to any master.
- Reset mid-cycle: rst_i forces IDLE in the same edge regardless of state, so slave cyc/stb drop the next cycle. A master still holding cyc after reset is re-arbitrated normally.
- Counter width: no wrap is possible, because the limit is reached first. CNT_W is checked by an initial assertion.

Test Plan:
- Single master: m0 reads the timer for 1 beat; slave acks 1 cycle after stb -> s_cyc_o rises 1 cycle after m0_cyc, m0_ack_o=1 for 1 cycle with m0_dat_o=s_dat_i, m1 outputs stay 0.
- Tie after reset: m0 and m1 assert cyc in the same cycle -> GNT0 first (grant_o=01). When m0 drops cyc -> GNT1 on the next edge (grant_o=10), with no IDLE cycle.
- Round-robin fairness: both masters continuously issue 1-beat cycles for 20 transactions -> grants alternate 0,1,0,1...; each master receives exactly 10 acks.
- Write passthrough: m1 writes 0x0000_1234 with sel=4'hF to 0x3002_0000 -> the slave sees adr/dat/sel/we exactly as driven while GNT1; m0 inputs toggling randomly are not visible on the slave.
- Timeout: slave never acks, TIMEOUT_CYCLES=16 -> m0_err_o=1 exactly 16 cycles after the first stb. The slave cyc is 0 in that ABORT cycle, and a pending m1 is granted next. A variant where the ack arrives in the 16th cycle -> ack is forwarded and no err.
- Reset mid-transfer: assert rst_i during GNT1 with stb high -> the next cycle has all slave outputs 0 and grant_o=00. After reset release with both requesting -> m0 is granted.
